// File: rtl/pixel_ram_arbiter_if.sv
// Writer-side bus of the pixel RAM arbiter: pixel write handshake plus
// buffer swap control. master = game-logic writer, slave = arbiter.
interface pixel_ram_arbiter_if #(
  parameter int unsigned DATA_W = 12
);
  logic              wr_valid;
  logic              wr_ready;
  logic [8:0]        wr_row;
  logic [9:0]        wr_col;
  logic [DATA_W-1:0] wr_data;
  logic              swap_req;
  logic              swap_pending;
  logic              swap_done;

  modport master (
    output wr_valid, wr_row, wr_col, wr_data, swap_req,
    input  wr_ready, swap_pending, swap_done
  );

  modport slave (
    input  wr_valid, wr_row, wr_col, wr_data, swap_req,
    output wr_ready, swap_pending, swap_done
  );
endinterface

// File: rtl/pixel_ram_arbiter.sv
// Shares the single-port double-buffered pixel RAM between VGA scan-out
// (always wins) and a FIFO-buffered pixel writer; swaps buffers at frame start.
module pixel_ram_arbiter #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DATA_W     = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          vga_rdn,
  input  logic [8:0]                    vga_row,
  input  logic [9:0]                    vga_col,
  input  logic                          vga_vs,
  output logic [DATA_W-1:0]             vga_din,
  pixel_ram_arbiter_if.slave            wr_bus,
  output logic                          front,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [19:0]                   ram_addr,
  output logic                          ram_we,
  output logic [DATA_W-1:0]             ram_wdata,
  input  logic [DATA_W-1:0]             ram_rdata
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef struct packed {
    logic [8:0]        row;
    logic [9:0]        col;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic {
    IDLE,
    PEND
  } swap_state_t;

  entry_t      mem [FIFO_DEPTH];
  entry_t      head_e;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [LW-1:0] level;

  swap_state_t state;
  logic        front_q;
  logic        swap_done_q;
  logic        vs_q;

  logic empty;
  logic push;
  logic pop;
  logic boundary;
  logic commit;

  // Handshake and slot decisions, all from registered state except the
  // scan-out request and vsync which are sampled live.
  assign empty    = (level == LW'(0));
  assign head_e   = mem[head];
  assign wr_bus.wr_ready = (level < LW'(FIFO_DEPTH)) && (state == IDLE) && !swap_done_q;
  assign push     = wr_bus.wr_valid && wr_bus.wr_ready;
  assign pop      = vga_rdn && !empty;
  assign boundary = vs_q && !vga_vs;
  assign commit   = (state == PEND) && boundary && empty && !pop;

  assign wr_bus.swap_pending = (state == PEND);
  assign wr_bus.swap_done    = swap_done_q;
  assign front               = front_q;
  assign fifo_level          = level;
  assign vga_din             = ram_rdata;

  // Port mux: reads own the port while rdn is low; idle slots drain the FIFO
  // into the back buffer.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = {front_q, vga_row, vga_col};
    ram_wdata = head_e.data;
    if (pop) begin
      ram_we   = 1'b1;
      ram_addr = {~front_q, head_e.row, head_e.col};
    end
  end

  // Entry storage is not reset; occupancy is tracked by level.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= '{row: wr_bus.wr_row, col: wr_bus.wr_col, data: wr_bus.wr_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      level <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Swap FSM: a request waits for a frame boundary with the FIFO fully drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      front_q     <= 1'b0;
      swap_done_q <= 1'b0;
      vs_q        <= 1'b1;
    end else begin
      vs_q        <= vga_vs;
      swap_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_bus.swap_req) state <= PEND;
        end
        PEND: begin
          if (commit) begin
            front_q     <= ~front_q;
            swap_done_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_ram_arbiter.sv
// Directed bench for pixel_ram_arbiter: read priority, backpressure, swap
// commit and deferral, same-cycle swap request, and mid-frame reset.
module tb_pixel_ram_arbiter;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned DW    = 12;

  logic          clk;
  logic          rst;
  logic          vga_rdn;
  logic [8:0]    vga_row;
  logic [9:0]    vga_col;
  logic          vga_vs;
  logic [DW-1:0] vga_din;
  logic          front;
  logic [3:0]    fifo_level;
  logic [19:0]   ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  int checks;
  int errors;

  pixel_ram_arbiter_if #(.DATA_W(DW)) bus ();

  pixel_ram_arbiter #(.FIFO_DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .vga_rdn    (vga_rdn),
    .vga_row    (vga_row),
    .vga_col    (vga_col),
    .vga_vs     (vga_vs),
    .vga_din    (vga_din),
    .wr_bus     (bus),
    .front      (front),
    .fifo_level (fifo_level),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] addr(input logic b, input int r, input int c);
    return {b, 9'(r), 10'(c)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    vga_rdn = 1'b1;
    vga_row = '0;
    vga_col = '0;
    vga_vs = 1'b1;
    ram_rdata = 12'h5A3;
    bus.wr_valid = 1'b0;
    bus.wr_row = '0;
    bus.wr_col = '0;
    bus.wr_data = '0;
    bus.swap_req = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    // Reset state and passthroughs
    sample();
    check("rst_front", 32'(front), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_pending", 32'(bus.swap_pending), 32'd0);
    check("rst_done", 32'(bus.swap_done), 32'd0);
    check("rst_ready", 32'(bus.wr_ready), 32'd1);
    check("rst_we", 32'(ram_we), 32'd0);
    check("din_pass", 32'(vga_din), 32'h5A3);
    step();
    vga_rdn = 1'b0;
    vga_row = 9'd3;
    vga_col = 10'd7;
    sample();
    check("read_addr", 32'(ram_addr), 32'(addr(1'b0, 3, 7)));

    // Read priority: a queued write waits for rdn to rise
    step();
    bus.wr_valid = 1'b1;
    bus.wr_row = 9'd10;
    bus.wr_col = 10'd20;
    bus.wr_data = 12'hABC;
    sample();
    check("prio_we_push", 32'(ram_we), 32'd0);
    step();
    bus.wr_valid = 1'b0;
    sample();
    check("prio_level1", 32'(fifo_level), 32'd1);
    check("prio_we_held", 32'(ram_we), 32'd0);
    step();
    vga_rdn = 1'b1;
    sample();
    check("prio_we", 32'(ram_we), 32'd1);
    check("prio_addr", 32'(ram_addr), 32'(addr(1'b1, 10, 20)));
    check("prio_wdata", 32'(ram_wdata), 32'hABC);
    step();
    sample();
    check("prio_level0", 32'(fifo_level), 32'd0);
    check("prio_we_idle", 32'(ram_we), 32'd0);

    // Backpressure: fill to 8 with reads holding the port
    step();
    vga_rdn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_row = 9'(i);
      bus.wr_col = 10'(i + 100);
      bus.wr_data = 12'(12'h100 + i);
      step();
    end
    bus.wr_row = 9'd9;
    bus.wr_col = 10'd9;
    bus.wr_data = 12'hFFF;
    sample();
    check("bp_level8", 32'(fifo_level), 32'd8);
    check("bp_ready0", 32'(bus.wr_ready), 32'd0);
    step();
    bus.wr_valid = 1'b0;
    sample();
    check("bp_no_9th", 32'(fifo_level), 32'd8);
    step();
    vga_rdn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sample();
      check("bp_drain_we", 32'(ram_we), 32'd1);
      check("bp_drain_addr", 32'(ram_addr), 32'(addr(1'b1, i, i + 100)));
      check("bp_drain_data", 32'(ram_wdata), 32'(12'h100 + i));
      step();
    end
    sample();
    check("bp_empty", 32'(fifo_level), 32'd0);
    check("bp_we_off", 32'(ram_we), 32'd0);

    // Swap commit with an empty FIFO
    step();
    bus.swap_req = 1'b1;
    step();
    bus.swap_req = 1'b0;
    sample();
    check("sw_pending", 32'(bus.swap_pending), 32'd1);
    check("sw_ready0", 32'(bus.wr_ready), 32'd0);
    step();
    vga_vs = 1'b0;
    sample();
    check("sw_bnd_done", 32'(bus.swap_done), 32'd0);
    check("sw_bnd_front", 32'(front), 32'd0);
    step();
    vga_vs = 1'b1;
    sample();
    check("sw_done", 32'(bus.swap_done), 32'd1);
    check("sw_front1", 32'(front), 32'd1);
    check("sw_pend0", 32'(bus.swap_pending), 32'd0);
    check("sw_ready_done", 32'(bus.wr_ready), 32'd0);
    step();
    sample();
    check("sw_done_once", 32'(bus.swap_done), 32'd0);
    check("sw_ready_back", 32'(bus.wr_ready), 32'd1);
    step();
    vga_rdn = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_row = 9'd1;
    bus.wr_col = 10'd2;
    bus.wr_data = 12'h123;
    step();
    bus.wr_valid = 1'b0;
    vga_rdn = 1'b1;
    sample();
    check("sw_wr_addr", 32'(ram_addr), 32'(addr(1'b0, 1, 2)));
    check("sw_wr_we", 32'(ram_we), 32'd1);
    step();
    vga_rdn = 1'b0;
    vga_row = 9'd5;
    vga_col = 10'd6;
    sample();
    check("sw_rd_addr", 32'(ram_addr), 32'(addr(1'b1, 5, 6)));

    // Deferred swap: boundary with 3 queued entries does not commit
    for (int i = 0; i < 3; i++) begin
      step();
      bus.wr_valid = 1'b1;
      bus.wr_row = 9'(20 + i);
      bus.wr_col = 10'(i);
      bus.wr_data = 12'(i);
    end
    step();
    bus.wr_valid = 1'b0;
    bus.swap_req = 1'b1;
    step();
    bus.swap_req = 1'b0;
    vga_vs = 1'b0;
    step();
    vga_vs = 1'b1;
    sample();
    check("df_level3", 32'(fifo_level), 32'd3);
    check("df_pending", 32'(bus.swap_pending), 32'd1);
    check("df_front", 32'(front), 32'd1);
    check("df_done0", 32'(bus.swap_done), 32'd0);
    check("df_ready0", 32'(bus.wr_ready), 32'd0);
    step();
    vga_rdn = 1'b1;
    repeat (3) step();
    vga_rdn = 1'b0;
    sample();
    check("df_drained", 32'(fifo_level), 32'd0);
    check("df_still_pend", 32'(bus.swap_pending), 32'd1);
    step();
    vga_vs = 1'b0;
    step();
    vga_vs = 1'b1;
    sample();
    check("df_done", 32'(bus.swap_done), 32'd1);
    check("df_front0", 32'(front), 32'd0);

    // swap_req in the same cycle as a boundary while idle
    step();
    step();
    bus.swap_req = 1'b1;
    vga_vs = 1'b0;
    step();
    bus.swap_req = 1'b0;
    vga_vs = 1'b1;
    sample();
    check("sim_pending", 32'(bus.swap_pending), 32'd1);
    check("sim_front", 32'(front), 32'd0);
    check("sim_done0", 32'(bus.swap_done), 32'd0);
    step();
    sample();
    check("sim_no_commit", 32'(bus.swap_done), 32'd0);
    step();
    vga_vs = 1'b0;
    step();
    vga_vs = 1'b1;
    sample();
    check("sim_done", 32'(bus.swap_done), 32'd1);
    check("sim_front1", 32'(front), 32'd1);

    // Mid-frame reset with 5 queued writes and a pending swap
    step();
    for (int i = 0; i < 5; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_row = 9'(30 + i);
      bus.wr_col = 10'(i);
      bus.wr_data = 12'(12'h200 + i);
      step();
    end
    bus.wr_valid = 1'b0;
    bus.swap_req = 1'b1;
    step();
    bus.swap_req = 1'b0;
    vga_rdn = 1'b1;
    sample();
    check("pre_rst_level", 32'(fifo_level), 32'd5);
    check("pre_rst_pend", 32'(bus.swap_pending), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_front", 32'(front), 32'd0);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_pend", 32'(bus.swap_pending), 32'd0);
    check("mid_rst_we", 32'(ram_we), 32'd0);
    step();
    rst = 1'b0;
    sample();
    check("post_rst_ready", 32'(bus.wr_ready), 32'd1);
    check("post_rst_level", 32'(fifo_level), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
